// File: rtl/product_accumulator.sv
// Counted, saturating accumulator for signed booth-multiplier products.
// IDLE -> ACCUM (sum len products) -> DONE (hold result until accepted).
module product_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic signed [15:0]      prod_in,
  input  logic                    prod_valid,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic                    busy,
  output logic                    sat
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LEN_W:0]   CNT_FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]   CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [LEN_W:0]   cnt, cnt_nx;
  logic             sat_r, sat_nx;
  logic [ACC_W:0]   sum;
  logic             ovf;
  logic [ACC_W-1:0] sum_sat;
  logic             take_start;
  logic [LEN_W:0]   load_cnt;

  // One guard bit: overflow shows as the two top bits of the sum disagreeing.
  assign sum     = {acc[ACC_W-1], acc} + {{(ACC_W-15){prod_in[15]}}, prod_in};
  assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
  assign sum_sat = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

  assign load_cnt   = (len == '0) ? CNT_FULL : {1'b0, len};
  assign take_start = start && ((state == IDLE) || (state == DONE && acc_ready));

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    sat_nx   = sat_r;
    case (state)
      IDLE: ;
      ACCUM: begin
        if (prod_valid) begin
          acc_nx = sum_sat;
          sat_nx = sat_r | ovf;
          cnt_nx = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_nx = DONE;
        end
      end
      DONE: begin
        if (acc_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // A start in DONE is only honoured alongside the result handshake.
    if (take_start) begin
      acc_nx   = '0;
      sat_nx   = 1'b0;
      cnt_nx   = load_cnt;
      state_nx = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat_r <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      sat_r <= sat_nx;
    end
  end

  assign acc_out   = acc;
  assign acc_valid = (state == DONE);
  assign busy      = (state == ACCUM);
  assign sat       = sat_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench: two instances (ACC_W=24 and ACC_W=17) share stimulus and are
// checked every cycle against an arithmetic model, plus literal checkpoints.
`timescale 1ns/100ps
module tb_product_accumulator;

  logic clk, rst, start, prod_valid, acc_ready;
  logic [3:0] len;
  logic signed [15:0] prod_in;
  logic signed [23:0] acc0;
  logic signed [16:0] acc1;
  logic valid0, busy0, sat0, valid1, busy1, sat1;

  int nvec = 0;
  int nmis = 0;

  product_accumulator #(.ACC_W(24), .LEN_W(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
    .prod_valid(prod_valid), .acc_out(acc0), .acc_valid(valid0),
    .acc_ready(acc_ready), .busy(busy0), .sat(sat0));

  product_accumulator #(.ACC_W(17), .LEN_W(4)) u1 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
    .prod_valid(prod_valid), .acc_out(acc1), .acc_valid(valid1),
    .acc_ready(acc_ready), .busy(busy1), .sat(sat1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: phase 0 idle, 1 summing, 2 holding result
  longint m_acc [2] = '{0, 0};
  int     m_cnt [2] = '{0, 0};
  int     m_ph  [2] = '{0, 0};
  bit     m_sat [2] = '{0, 0};

  function automatic int wid(int i);
    return (i == 0) ? 24 : 17;
  endfunction

  function automatic longint clamp(longint v, int w);
    longint hi = (longint'(1) << (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] <= 0; m_cnt[i] <= 0; m_ph[i] <= 0; m_sat[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start && (m_ph[i] == 0 || (m_ph[i] == 2 && acc_ready))) begin
          m_acc[i] <= 0;
          m_sat[i] <= 0;
          m_cnt[i] <= (len == 0) ? 16 : int'(len);
          m_ph[i]  <= 1;
        end else if (m_ph[i] == 2 && acc_ready) begin
          m_ph[i] <= 0;
        end else if (m_ph[i] == 1 && prod_valid) begin
          m_acc[i] <= clamp(m_acc[i] + longint'(prod_in), wid(i));
          m_sat[i] <= m_sat[i] |
                      (clamp(m_acc[i] + longint'(prod_in), wid(i)) != m_acc[i] + longint'(prod_in));
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) m_ph[i] <= 2;
        end
      end
    end
  end

  task automatic cmp(input string name, input longint got, input longint exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("acc_out0", longint'(acc0), m_acc[0]);
    cmp("acc_valid0", longint'(valid0), longint'(m_ph[0] == 2));
    cmp("busy0", longint'(busy0), longint'(m_ph[0] == 1));
    cmp("sat0", longint'(sat0), longint'(m_sat[0]));
    cmp("acc_out1", longint'(acc1), m_acc[1]);
    cmp("acc_valid1", longint'(valid1), longint'(m_ph[1] == 2));
    cmp("busy1", longint'(busy1), longint'(m_ph[1] == 1));
    cmp("sat1", longint'(sat1), longint'(m_sat[1]));
  end

  // Inputs are applied 1ns after an edge and consumed by the next edge;
  // the task returns 1ns after that consuming edge.
  task automatic drive(input logic s, input int l, input logic pv, input int p, input logic r);
    start = s; len = 4'(l); prod_valid = pv; prod_in = 16'(p); acc_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; len = 0; prod_valid = 0; prod_in = 0; acc_ready = 0;
    #1 rst = 1'b0;
    #1;
    cmp("reset_acc0", longint'(acc0), 0);
    cmp("reset_valid0", longint'(valid0), 0);
    cmp("reset_busy0", longint'(busy0), 0);
    cmp("reset_sat0", longint'(sat0), 0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;

    // four products of -80
    drive(1, 4, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, -80, 0);
    cmp("neg80_valid", longint'(valid0), 1);
    cmp("neg80_acc", longint'(acc0), -320);
    cmp("neg80_sat", longint'(sat0), 0);
    drive(0, 0, 0, 0, 1);

    // gapped products, busy through the gaps
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 1, 100, 0);
    idle(1); cmp("gap_busy_a", longint'(busy0), 1);
    idle(1); cmp("gap_busy_b", longint'(busy0), 1);
    drive(0, 0, 1, 200, 0);
    idle(2); cmp("gap_busy_c", longint'(busy0), 1);
    drive(0, 0, 1, 300, 0);
    cmp("gap_acc", longint'(acc0), 600);
    cmp("gap_valid", longint'(valid0), 1);
    drive(0, 0, 0, 0, 1);

    // saturation in the 17-bit instance only
    drive(1, 4, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 32767, 0);
    cmp("sat17_acc", longint'(acc1), 65535);
    cmp("sat17_flag", longint'(sat1), 1);
    cmp("sat24_acc", longint'(acc0), 131068);
    cmp("sat24_flag", longint'(sat0), 0);
    drive(0, 0, 0, 0, 1);

    // hold under backpressure, then accept together with a new start
    drive(1, 2, 0, 0, 0);
    drive(0, 0, 1, 10, 0);
    drive(0, 0, 1, 20, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 3, 1, 99, 0);
      cmp("hold_acc", longint'(acc0), 30);
      cmp("hold_valid", longint'(valid0), 1);
    end
    drive(1, 1, 0, 0, 1);
    cmp("restart_busy", longint'(busy0), 1);
    drive(0, 0, 1, 7, 0);
    cmp("restart_acc", longint'(acc0), 7);
    drive(0, 0, 0, 0, 1);

    // async reset mid-accumulation
    drive(1, 5, 0, 0, 0);
    drive(0, 0, 1, 1000, 0);
    drive(0, 0, 1, 2000, 0);
    #0.5 rst = 1'b0;
    #1;
    cmp("areset_acc0", longint'(acc0), 0);
    cmp("areset_acc1", longint'(acc1), 0);
    cmp("areset_busy", longint'(busy0), 0);
    cmp("areset_valid", longint'(valid0), 0);
    #2 rst = 1'b1;
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 1, -1, 0);
    cmp("post_reset_acc", longint'(acc0), -1);
    cmp("post_reset_acc17", longint'(acc1), -1);
    drive(0, 0, 0, 0, 1);

    // products in IDLE are ignored; len=0 means sixteen
    drive(0, 0, 1, 5, 0);
    drive(0, 0, 1, 5, 0);
    cmp("idle_prod_ignored", longint'(acc0), -1);
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      cmp("len0_not_done", longint'(valid0), 0);
      drive(0, 0, 1, 1, 0);
    end
    cmp("len0_acc", longint'(acc0), 16);
    cmp("len0_valid", longint'(valid0), 1);
    drive(0, 0, 0, 0, 1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int p;
      p = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 32767 : -32768)
                                   : int'($urandom_range(65535)) - 32768;
      drive($urandom_range(7) == 0, int'($urandom_range(15)), $urandom_range(2) != 0,
            p, $urandom_range(2) == 0);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
